// File: rtl/logic_serial_ctrl_if.sv
// Request/response channel between the issue stage (master) and the
// bit-serial logic controller (slave).
interface logic_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/logic_serial_ctrl.sv
// Bit-serial logic controller: accepts a WIDTH-bit (op, A, B) request,
// streams the operands LSB-first through an external combinational 1-bit
// logic slice and returns the reassembled result word.
module logic_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_serial_ctrl_if.slave   bus,
  output logic                 lu_a,
  output logic                 lu_b,
  output logic                 lu_opsel0,
  output logic                 lu_opsel1,
  output logic                 lu_opsel2,
  input  logic                 lu_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_lu_a;
  logic             r_lu_b;
  logic [2:0]       r_lu_op;

  logic             w_accept;
  logic             w_rsvd;
  logic             w_last;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_rsvd   = bus.req_op[2];
  assign w_last   = (r_state == S_ISSUE) && (r_cnt == CW'(WIDTH - 1));

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_res;
  assign bus.rsp_err   = r_rsp_err;

  assign lu_a      = r_lu_a;
  assign lu_b      = r_lu_b;
  assign lu_opsel0 = r_lu_op[0];
  assign lu_opsel1 = r_lu_op[1];
  assign lu_opsel2 = r_lu_op[2];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = w_rsvd ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shifting, result assembly, response and slice-drive registers.
  // The slice-drive registers are preloaded with the next operand bit
  // (A_sh[1]) so that during each ISSUE cycle they equal the current A_sh[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_lu_a      <= 1'b0;
      r_lu_b      <= 1'b0;
      r_lu_op     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh <= bus.req_a;
            r_b_sh <= bus.req_b;
            r_cnt  <= '0;
            if (w_rsvd) begin
              r_res       <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
            end else begin
              r_rsp_err <= 1'b0;
              r_lu_a    <= bus.req_a[0];
              r_lu_b    <= bus.req_b[0];
              r_lu_op   <= bus.req_op;
            end
          end
        end
        S_ISSUE: begin
          r_res  <= {lu_out, r_res[WIDTH-1:1]};
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          if (w_last) begin
            r_cnt       <= '0;
            r_lu_a      <= 1'b0;
            r_lu_b      <= 1'b0;
            r_lu_op     <= '0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_lu_a <= r_a_sh[1];
            r_lu_b <= r_b_sh[1];
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_serial_ctrl.sv
// Self-checking bench for logic_serial_ctrl: directed vector table,
// hand-written reset-abort sequence and randomized ops against a
// word-level reference model.
module tb_logic_serial_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_serial_ctrl_if #(.WIDTH(W)) bus ();

  logic lu_a, lu_b, lu_opsel0, lu_opsel1, lu_opsel2, lu_out;

  logic_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_opsel0 (lu_opsel0),
    .lu_opsel1 (lu_opsel1),
    .lu_opsel2 (lu_opsel2),
    .lu_out    (lu_out)
  );

  // External 1-bit logic slice.
  always_comb begin
    lu_out = 1'b0;
    case ({lu_opsel2, lu_opsel1, lu_opsel0})
      3'd0: lu_out = lu_a & lu_b;
      3'd1: lu_out = lu_a | lu_b;
      3'd2: lu_out = lu_a ^ lu_b;
      3'd3: lu_out = ~lu_a;
      default: lu_out = 1'b0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: result computed directly from the opcode rules.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic e);
    e = 1'b0;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: d = a ^ b;
      3'd3: d = ~a;
      default: begin d = '0; e = 1'b1; end
    endcase
  endfunction

  function automatic logic [4:0] lu_vec();
    return {lu_a, lu_b, lu_opsel2, lu_opsel1, lu_opsel0};
  endfunction

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 after the
  // response handshake. Request inputs stay valid with junk after accept.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input logic [W-1:0] exp_d, input logic exp_e);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    if (!exp_e) begin
      for (int k = 0; k < W; k++) begin
        bus.req_op = 3'($urandom);
        bus.req_a  = W'($urandom);
        bus.req_b  = W'($urandom);
        check("lu_a_bit",       lu_a, a[k]);
        check("lu_b_bit",       lu_b, b[k]);
        check("lu_opsel",       {lu_opsel2, lu_opsel1, lu_opsel0}, op);
        check("rsp_valid_busy", bus.rsp_valid, 0);
        check("req_ready_busy", bus.req_ready, 0);
        @(posedge clk); #1;
      end
    end else begin
      bus.req_op = 3'($urandom);
      bus.req_a  = W'($urandom);
    end
    for (int s = 0; s < stall; s++) begin
      check("rsp_valid_stall", bus.rsp_valid, 1);
      check("rsp_data_stall",  bus.rsp_data, exp_d);
      check("rsp_err_stall",   bus.rsp_err, exp_e);
      check("req_ready_stall", bus.req_ready, 0);
      check("lu_zero_done",    lu_vec(), 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_data",  bus.rsp_data, exp_d);
    check("rsp_err",   bus.rsp_err, exp_e);
    check("lu_zero_rsp", lu_vec(), 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("rsp_valid_cleared", bus.rsp_valid, 0);
    check("req_ready_after",   bus.req_ready, 1);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           stall;
    logic [W-1:0] d;
    logic         e;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb, rd;
    logic         re;

    vecs[0] = '{op: 3'd0, a: 8'hF0, b: 8'h3C, stall: 0, d: 8'h30, e: 1'b0};
    vecs[1] = '{op: 3'd2, a: 8'hAA, b: 8'hFF, stall: 0, d: 8'h55, e: 1'b0};
    vecs[2] = '{op: 3'd3, a: 8'h0F, b: 8'h5A, stall: 0, d: 8'hF0, e: 1'b0};
    vecs[3] = '{op: 3'd5, a: 8'hFF, b: 8'h00, stall: 2, d: 8'h00, e: 1'b1};
    vecs[4] = '{op: 3'd1, a: 8'h01, b: 8'h80, stall: 5, d: 8'h81, e: 1'b0};
    vecs[5] = '{op: 3'd7, a: 8'h12, b: 8'h34, stall: 0, d: 8'h00, e: 1'b1};
    vecs[6] = '{op: 3'd0, a: 8'hFF, b: 8'hFF, stall: 1, d: 8'hFF, e: 1'b0};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #2;
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data",  bus.rsp_data, 0);
    check("reset_rsp_err",   bus.rsp_err, 0);
    check("reset_lu",        lu_vec(), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table; entries 1 and 2 run back-to-back.
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].d, vecs[i].e);

    // Reset asserted at bit 3 of an AND aborts the operation.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_a     = 8'h08;
    bus.req_b     = 8'hFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_lu_a_bit3", lu_a, 1);
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", bus.req_ready, 1);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_data",  bus.rsp_data, 0);
    check("abort_lu",        lu_vec(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < W + 2; c++) begin
      check("abort_no_rsp", bus.rsp_valid, 0);
      @(posedge clk); #1;
    end
    run_op(3'd0, 8'hF0, 8'h3C, 0, 8'h30, 1'b0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      model(rop, ra, rb, rd, re);
      run_op(rop, ra, rb, int'($urandom_range(0, 3)), rd, re);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
